// File: rtl/cpu_trace_emitter_pkg.sv
// Shared ASCII constants, emitter state encoding and the nibble-to-hex-character helper.
// Pure declarations: no latency or backpressure of its own.
package trace_pkg;

    localparam logic [7:0] CH_CARET  = 8'h5e;
    localparam logic [7:0] CH_AT     = 8'h40;
    localparam logic [7:0] CH_COLON  = 8'h3a;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2a;
    localparam logic [7:0] CH_SP     = 8'h20;
    localparam logic [7:0] CH_LT     = 8'h3c;
    localparam logic [7:0] CH_EQ     = 8'h3d;
    localparam logic [7:0] CH_HASH   = 8'h23;
    localparam logic [7:0] CH_ZERO   = 8'h30;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_CARET  = 4'd1;
    localparam logic [3:0] ST_TIME   = 4'd2;
    localparam logic [3:0] ST_AT     = 4'd3;
    localparam logic [3:0] ST_PC     = 4'd4;
    localparam logic [3:0] ST_COLON  = 4'd5;
    localparam logic [3:0] ST_SIGIL  = 4'd6;
    localparam logic [3:0] ST_TARGET = 4'd7;
    localparam logic [3:0] ST_SP1    = 4'd8;
    localparam logic [3:0] ST_LT     = 4'd9;
    localparam logic [3:0] ST_EQ     = 4'd10;
    localparam logic [3:0] ST_SP2    = 4'd11;
    localparam logic [3:0] ST_DATA   = 4'd12;
    localparam logic [3:0] ST_HASH   = 4'd13;

    // 'a' is 8'h61, so 8'h57 + 10 lands on it.
    function automatic logic [7:0] hex2ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});
    endfunction

endpackage

// File: rtl/cpu_trace_emitter_if.sv
// Event-in / character-out bundle of the trace emitter; master drives events, slave is the emitter.
// Character side is valid/ready; a start is only honoured while busy_o is low.
interface cpu_trace_emitter_if;
    logic        start_i;
    logic        kind_i;
    logic [13:0] time_i;
    logic [31:0] pc_i;
    logic [31:0] target_i;
    logic [31:0] data_i;
    logic        char_ready_i;
    logic        char_valid_o;
    logic [7:0]  char_o;
    logic        busy_o;
    logic        done_o;

    modport master (
        output start_i, kind_i, time_i, pc_i, target_i, data_i, char_ready_i,
        input  char_valid_o, char_o, busy_o, done_o
    );

    modport slave (
        input  start_i, kind_i, time_i, pc_i, target_i, data_i, char_ready_i,
        output char_valid_o, char_o, busy_o, done_o
    );
endinterface

// File: rtl/cpu_trace_emitter_bin2bcd.sv
// Combinational double-dabble: 14-bit binary to four BCD digits (inputs above 9999 lose the top digit).
// Zero latency, no handshake.
module bin2bcd (
    input  logic [13:0] bin_i,
    output logic [15:0] bcd_o
);
    logic [15:0] acc;

    always_comb begin
        acc = '0;
        for (int i = 13; i >= 0; i--) begin
            for (int d = 0; d < 4; d++) begin
                if (acc[4*d +: 4] >= 4'd5) begin
                    acc[4*d +: 4] = acc[4*d +: 4] + 4'd3;
                end
            end
            acc = {acc[14:0], bin_i[i]};
        end
        bcd_o = acc;
    end
endmodule

// File: rtl/cpu_trace_emitter.sv
// Serialises one write-back event into a "^time@pc:$reg <= data#" / "^time@pc:*addr <= data#" line.
// First char valid the cycle after start; one char per valid&ready cycle, outputs hold while ready is low.
module cpu_trace_emitter
    import trace_pkg::*;
#(
    parameter int unsigned TIME_MAX = 9999
) (
    input logic clk,
    input logic reset,
    cpu_trace_emitter_if.slave t
);
    localparam logic [13:0] TMAX = 14'(TIME_MAX);

    logic [3:0]  state_q, state_d;
    logic        kind_q, kind_d;
    logic [13:0] time_q, time_d;
    logic [31:0] pc_q, pc_d, target_q, target_d, data_q, data_d;
    logic [2:0]  idx_q, idx_d;
    logic [1:0]  didx_q, didx_d;
    logic [15:0] time_bcd, tgt_bcd;
    logic [1:0]  time_msd, tgt_msd;
    logic [3:0]  time_dig, tgt_dig;
    logic [7:0]  ch;
    logic        adv;

    bin2bcd u_time_bcd (.bin_i(time_q), .bcd_o(time_bcd));
    bin2bcd u_tgt_bcd  (.bin_i({9'd0, target_q[4:0]}), .bcd_o(tgt_bcd));

    assign adv      = (state_q != ST_IDLE) && t.char_ready_i;
    assign time_msd = (time_bcd[15:12] != 4'd0) ? 2'd3 :
                      (time_bcd[11:8]  != 4'd0) ? 2'd2 :
                      (time_bcd[7:4]   != 4'd0) ? 2'd1 : 2'd0;
    assign tgt_msd  = (tgt_bcd[15:4] != 12'd0) ? 2'd1 : 2'd0;
    assign time_dig = time_bcd[{didx_q, 2'b00} +: 4];
    assign tgt_dig  = tgt_bcd[{didx_q, 2'b00} +: 4];

    // Hex fields count idx_q down from 7 and wrap back to 7, so it is ready for the next field.
    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        time_d   = time_q;
        pc_d     = pc_q;
        target_d = target_q;
        data_d   = data_q;
        idx_d    = idx_q;
        didx_d   = didx_q;
        ch       = 8'h00;
        case (state_q)
            ST_IDLE: if (t.start_i) begin
                state_d  = ST_CARET;
                kind_d   = t.kind_i;
                time_d   = (t.time_i > TMAX) ? TMAX : t.time_i;
                pc_d     = t.pc_i;
                target_d = t.target_i;
                data_d   = t.data_i;
            end
            ST_CARET: begin
                ch = CH_CARET;
                if (adv) begin state_d = ST_TIME; didx_d = time_msd; end
            end
            ST_TIME: begin
                ch = CH_ZERO + {4'h0, time_dig};
                if (adv) begin
                    if (didx_q == 2'd0) state_d = ST_AT;
                    else                didx_d  = didx_q - 2'd1;
                end
            end
            ST_AT:    begin ch = CH_AT;    if (adv) state_d = ST_PC;    end
            ST_PC: begin
                ch = hex2ascii(pc_q[{idx_q, 2'b00} +: 4]);
                if (adv) begin
                    idx_d = idx_q - 3'd1;
                    if (idx_q == 3'd0) state_d = ST_COLON;
                end
            end
            ST_COLON: begin ch = CH_COLON; if (adv) state_d = ST_SIGIL; end
            ST_SIGIL: begin
                ch = kind_q ? CH_STAR : CH_DOLLAR;
                if (adv) begin state_d = ST_TARGET; didx_d = tgt_msd; end
            end
            ST_TARGET: begin
                if (kind_q) begin
                    ch = hex2ascii(target_q[{idx_q, 2'b00} +: 4]);
                    if (adv) begin
                        idx_d = idx_q - 3'd1;
                        if (idx_q == 3'd0) state_d = ST_SP1;
                    end
                end else begin
                    ch = CH_ZERO + {4'h0, tgt_dig};
                    if (adv) begin
                        if (didx_q == 2'd0) state_d = ST_SP1;
                        else                didx_d  = didx_q - 2'd1;
                    end
                end
            end
            ST_SP1:   begin ch = CH_SP;    if (adv) state_d = ST_LT;    end
            ST_LT:    begin ch = CH_LT;    if (adv) state_d = ST_EQ;    end
            ST_EQ:    begin ch = CH_EQ;    if (adv) state_d = ST_SP2;   end
            ST_SP2:   begin ch = CH_SP;    if (adv) state_d = ST_DATA;  end
            ST_DATA: begin
                ch = hex2ascii(data_q[{idx_q, 2'b00} +: 4]);
                if (adv) begin
                    idx_d = idx_q - 3'd1;
                    if (idx_q == 3'd0) state_d = ST_HASH;
                end
            end
            ST_HASH:  begin ch = CH_HASH;  if (adv) state_d = ST_IDLE;  end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            kind_q   <= 1'b0;
            time_q   <= '0;
            pc_q     <= '0;
            target_q <= '0;
            data_q   <= '0;
            idx_q    <= 3'd7;
            didx_q   <= 2'd0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            time_q   <= time_d;
            pc_q     <= pc_d;
            target_q <= target_d;
            data_q   <= data_d;
            idx_q    <= idx_d;
            didx_q   <= didx_d;
        end
    end

    assign t.char_valid_o = (state_q != ST_IDLE);
    assign t.busy_o       = (state_q != ST_IDLE);
    assign t.char_o       = ch;
    assign t.done_o       = (state_q == ST_HASH) && t.char_ready_i;
endmodule

// File: tb/tb_cpu_trace_emitter.sv
// Directed bench for cpu_trace_emitter: builds each emitted line and compares it with hand-written strings.
module tb_cpu_trace_emitter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    cpu_trace_emitter_if bus ();

    cpu_trace_emitter #(.TIME_MAX(9999)) dut (
        .clk   (clk),
        .reset (reset),
        .t     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},  {31'd0, bus.busy_o},       32'd0);
        chk({tag, "_valid"}, {31'd0, bus.char_valid_o}, 32'd0);
        chk({tag, "_char"},  {24'd0, bus.char_o},       32'd0);
        chk({tag, "_done"},  {31'd0, bus.done_o},       32'd0);
    endtask

    // Called at a negedge; leaves start high when hold is set.
    task automatic launch(input logic k, input logic [13:0] tm, input logic [31:0] p,
                          input logic [31:0] tg, input logic [31:0] d, input bit hold);
        bus.kind_i   = k;
        bus.time_i   = tm;
        bus.pc_i     = p;
        bus.target_i = tg;
        bus.data_i   = d;
        bus.start_i  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) bus.start_i = 1'b0;
    endtask

    // mode 0: ready always high; mode 1: ready high every third cycle.
    task automatic collect(input string tag, input string exp, input int mode);
        string      got;
        bit         fin;
        bit         stalled;
        bit         rdy;
        logic [7:0] last;
        int         n;
        got = "";
        fin = 1'b0;
        stalled = 1'b0;
        last = 8'h00;
        n = 0;
        chk({tag, "_busy_first"}, {31'd0, bus.busy_o}, 32'd1);
        for (int c = 0; c < 400 && !fin; c++) begin
            rdy = (mode == 0) ? 1'b1 : ((c % 3) == 0);
            bus.char_ready_i = rdy;
            #1;
            if (mode == 0) chk({tag, "_valid"}, {31'd0, bus.char_valid_o}, 32'd1);
            if (bus.char_valid_o) begin
                if (stalled) chk({tag, "_stable"}, {24'd0, bus.char_o}, {24'd0, last});
                if (rdy) begin
                    got = $sformatf("%s%c", got, bus.char_o);
                    chk({tag, "_done_pulse"}, {31'd0, bus.done_o}, {31'd0, bus.char_o == 8'h23});
                    if (bus.char_o == 8'h23) fin = 1'b1;
                end
                last = bus.char_o;
                stalled = !rdy;
            end
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk({tag, "_finished"}, {31'd0, fin}, 32'd1);
        checks++;
        assert (got == exp) else begin
            errors++;
            $error("FAIL %s_line observed=\"%s\" expected=\"%s\"", tag, got, exp);
        end
        if (mode == 0) chk({tag, "_cycles"}, n, exp.len());
        bus.char_ready_i = 1'b1;
        #1;
        if (!bus.start_i) chk_idle({tag, "_after"});
    endtask

    initial begin
        bus.start_i      = 1'b0;
        bus.kind_i       = 1'b0;
        bus.time_i       = '0;
        bus.pc_i         = '0;
        bus.target_i     = '0;
        bus.data_i       = '0;
        bus.char_ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_idle("reset");
        reset = 1'b0;
        @(negedge clk);
        chk_idle("idle");

        launch(1'b0, 14'd1024, 32'h000030fc, 32'd2, 32'h89abcdef, 1'b0);
        collect("reg", "^1024@000030fc:$2 <= 89abcdef#", 0);

        launch(1'b1, 14'd0, 32'h00003000, 32'h0000000c, 32'h0, 1'b0);
        collect("mem", "^0@00003000:*0000000c <= 00000000#", 0);

        launch(1'b0, 14'd12000, 32'h0, 32'd31, 32'h1, 1'b0);
        collect("sat", "^9999@00000000:$31 <= 00000001#", 0);

        launch(1'b0, 14'd100, 32'hdeadbeef, 32'hffffffe0, 32'hcafef00d, 1'b0);
        collect("regmask", "^100@deadbeef:$0 <= cafef00d#", 0);

        launch(1'b0, 14'd1024, 32'h000030fc, 32'd2, 32'h89abcdef, 1'b0);
        collect("bp", "^1024@000030fc:$2 <= 89abcdef#", 1);

        // Start held high: new field values while busy must not disturb the current line.
        launch(1'b1, 14'd0, 32'h00003000, 32'h0000000c, 32'h0, 1'b1);
        bus.kind_i   = 1'b0;
        bus.time_i   = 14'd12000;
        bus.pc_i     = 32'h0;
        bus.target_i = 32'd31;
        bus.data_i   = 32'h1;
        collect("b2b_a", "^0@00003000:*0000000c <= 00000000#", 0);
        chk("b2b_gap_busy",  {31'd0, bus.busy_o},       32'd0);
        chk("b2b_gap_valid", {31'd0, bus.char_valid_o}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        bus.start_i = 1'b0;
        collect("b2b_b", "^9999@00000000:$31 <= 00000001#", 0);

        launch(1'b0, 14'd1024, 32'h000030fc, 32'd2, 32'h89abcdef, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("mid_char",  {24'd0, bus.char_o},       32'h30);
        chk("mid_valid", {31'd0, bus.char_valid_o}, 32'd1);
        reset = 1'b1;
        #1;
        chk_idle("mid_reset");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        launch(1'b0, 14'd100, 32'hdeadbeef, 32'hffffffe0, 32'hcafef00d, 1'b0);
        collect("post_reset", "^100@deadbeef:$0 <= cafef00d#", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
